pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter BALL_SIZE, default 8, ball square side in pixels.
REQ-002 SHALL have parameter PAD_W, default 8, and PAD_H, default 64, paddle width and height in pixels.
REQ-003 SHALL have parameter BALL_SPD, default 2, and PAD_SPD, default 4, pixels moved per frame.
REQ-004 SHALL have parameter SERVE_FRAMES, default 60, frames held before a serve.
REQ-005 SHALL have parameter WIN_SCORE, default 7, the score that ends the game.
REQ-006 SHALL have port clk50M, input, 1, the single system clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port VS, input, 1, active-low vertical sync from the VGA timing chain.
REQ-009 SHALL have ports p1_up, p1_down, p2_up, p2_down, start, all input, 1, asynchronous push-buttons, active-high.
REQ-010 SHALL have ports ball_x, ball_y, output, 10 each, the ball's top-left corner in the 640x480 active area.
REQ-011 SHALL have ports paddle_one_x, paddle_one_y, paddle_two_x, paddle_two_y, output, 10 each, the paddles' top-left corners.
REQ-012 SHALL have ports score_one, score_two, output, 4 each, and game_over, output, 1.

Function
REQ-013 SHALL pass every button and VS through a 2-flop synchronizer before any use.
REQ-014 SHALL generate frame_tick as a 1-cycle pulse on each falling edge of synchronized VS; all position, score and frame-counter updates SHALL occur only on frame_tick, and outputs SHALL be registered with the new values visible 1 cycle after frame_tick.
REQ-015 SHALL hold paddle_one_x = 16 and paddle_two_x = 616 constant.
REQ-016 SHALL implement states IDLE, SERVE, PLAY, POINT, GAMEOVER.
REQ-017 SHALL keep the ball centred at (316,236) in IDLE, SERVE and GAMEOVER, and freeze both paddles in IDLE and GAMEOVER.
REQ-018 SHALL leave IDLE or GAMEOVER for SERVE on frame_tick with synchronized start high, and SHALL clear both scores and game_over on that transition.
REQ-019 SHALL count frame_ticks in SERVE and enter PLAY on the SERVE_FRAMES-th tick, launching the ball with dy = down and dx set toward the player who lost the last point (right after reset/new game).
REQ-020 SHALL ignore start in SERVE, PLAY and POINT.
REQ-021 SHALL move a paddle by PAD_SPD per frame in SERVE, PLAY and POINT: up clamps at 0, down clamps at 480-PAD_H (416 by default), and up and down together mean no move.
REQ-022 SHALL move the ball in PLAY by BALL_SPD on each axis per frame, using unsigned 10-bit arithmetic with clamping and no wrap-around.
REQ-023 SHALL, moving down, when ball_y+BALL_SIZE+BALL_SPD >= 480, set ball_y = 480-BALL_SIZE and set dy to up; moving up, when ball_y <= BALL_SPD, set ball_y = 0 and set dy to down.
REQ-024 SHALL define paddle overlap as ball_y+BALL_SIZE > paddle_y AND ball_y < paddle_y+PAD_H, using current-frame values.
REQ-025 SHALL, moving left with ball_x-BALL_SPD <= 24 and overlap with paddle one, set ball_x = 24 and set dx to right; moving right with ball_x+BALL_SIZE+BALL_SPD >= 616 and overlap with paddle two, set ball_x = 616-BALL_SIZE and set dx to left.
REQ-026 SHALL, with no paddle hit, treat ball_x <= BALL_SPD (moving left) as a point for player two and ball_x+BALL_SIZE+BALL_SPD >= 640 (moving right) as a point for player one, and enter POINT.
REQ-027 SHALL apply wall and paddle bounces independently when both occur in the same frame; a point SHALL override any bounce.
REQ-028 SHALL, in POINT, on the next frame_tick increment the scorer's score and enter GAMEOVER with game_over = 1 if the new score equals WIN_SCORE, otherwise enter SERVE with the frame counter cleared.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force: state IDLE, ball (316,236), dx right, dy down, both paddle y = 208, scores 0, game_over 0, frame counter 0, synchronizers cleared.
REQ-030 SHALL apply reset at any time, including mid-PLAY, with no partial update surviving.

Verification
REQ-031 Bench SHALL check: reset, then start held for 1 frame, then 60 frames -> state PLAY, and the next frame gives ball (318,238).
REQ-032 Bench SHALL check: p1_up held from paddle_one_y = 208 for 60 frames -> paddle_one_y reaches 0 and stays 0; p1_up and p1_down together -> no change.
REQ-033 Bench SHALL check: ball at y = 471 moving down -> ball_y = 472 and dy up on the next frame; ball at x = 25 moving left with paddle_one_y = ball_y-10 -> ball_x = 24 and dx right.
REQ-034 Bench SHALL check: ball moving left at x = 2 with paddle one away -> POINT, score_two +1, then SERVE, then after 60 frames a serve toward the left.
REQ-035 Bench SHALL check: score_one = 6 and a player-one point -> score_one = 7, game_over = 1, state GAMEOVER; then start -> scores 0 and state SERVE.
REQ-036 Bench SHALL check: rst_n pulsed low mid-PLAY, asynchronously to clk50M -> all outputs at REQ-029 values before the next clock edge.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: two-player Pong game state machine. It updates the ball, the paddles and the
// scores once per video frame. A frame starts on the falling edge of the synchronized VS.
//
// Ports
//   clk50M                         system clock
//   rst_n                          asynchronous active-low reset
//   VS                             active-low vertical sync from the VGA timing chain
//   p1_up, p1_down, p2_up, p2_down paddle push-buttons (asynchronous, active-high)
//   start                          new-game push-button (asynchronous, active-high)
//   ball_x, ball_y                 ball top-left corner, 640x480 active area
//   paddle_one_x/y, paddle_two_x/y paddle top-left corners
//   score_one, score_two           player scores
//   game_over                      set once a player reaches WIN_SCORE
module pong_game_ctrl #(
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned PAD_W        = 8,
  parameter int unsigned PAD_H        = 64,
  parameter int unsigned BALL_SPD     = 2,
  parameter int unsigned PAD_SPD      = 4,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 7
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic       VS,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_one_x,
  output logic [9:0] paddle_one_y,
  output logic [9:0] paddle_two_x,
  output logic [9:0] paddle_two_y,
  output logic [3:0] score_one,
  output logic [3:0] score_two,
  output logic       game_over
);

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam logic [9:0] BALL_X0   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y0   = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0] PAD1_X    = 10'd16;
  localparam logic [9:0] PAD2_X    = 10'd616;
  localparam logic [9:0] PAD_Y0    = 10'((SCREEN_H - PAD_H) / 2);
  localparam logic [9:0] PAD_Y_MAX = 10'(SCREEN_H - PAD_H);

  // 11-bit constants so that sums of a 10-bit coordinate and an offset cannot wrap.
  localparam logic [10:0] W_BS     = 11'(BALL_SIZE);
  localparam logic [10:0] W_BSPD   = 11'(BALL_SPD);
  localparam logic [10:0] W_PSPD   = 11'(PAD_SPD);
  localparam logic [10:0] W_PH     = 11'(PAD_H);
  localparam logic [10:0] W_SCR_W  = 11'(SCREEN_W);
  localparam logic [10:0] W_SCR_H  = 11'(SCREEN_H);
  localparam logic [10:0] HIT1_X   = 11'(16 + PAD_W);  // paddle one right face
  localparam logic [10:0] HIT2_X   = 11'(616);         // paddle two left face

  localparam int unsigned      CNT_W    = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StServe    = 3'd1,
    StPlay     = 3'd2,
    StPoint    = 3'd3,
    StGameOver = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Input synchronizers and frame tick
  // ---------------------------------------------------------------------------------------------
  logic [5:0] r_sync1, r_sync2;
  logic       r_vs_prev;
  logic       w_vs, w_p1_up, w_p1_dn, w_p2_up, w_p2_dn, w_start;
  logic       w_frame_tick;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_vs_prev <= 1'b0;
    end else begin
      r_sync1   <= {VS, p1_up, p1_down, p2_up, p2_down, start};
      r_sync2   <= r_sync1;
      r_vs_prev <= w_vs;
    end
  end

  assign {w_vs, w_p1_up, w_p1_dn, w_p2_up, w_p2_dn, w_start} = r_sync2;
  assign w_frame_tick = r_vs_prev & ~w_vs;

  // ---------------------------------------------------------------------------------------------
  // Game state
  // ---------------------------------------------------------------------------------------------
  state_e           r_state, w_state_nxt;
  logic [9:0]       r_ball_x, w_ball_x_nxt;
  logic [9:0]       r_ball_y, w_ball_y_nxt;
  logic             r_dx, w_dx_nxt;                    // 1 = right
  logic             r_dy, w_dy_nxt;                    // 1 = down
  logic [9:0]       r_pad1_y, w_pad1_y_nxt;
  logic [9:0]       r_pad2_y, w_pad2_y_nxt;
  logic [3:0]       r_score_one, w_score_one_nxt;
  logic [3:0]       r_score_two, w_score_two_nxt;
  logic             r_game_over, w_game_over_nxt;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic             r_serve_right, w_serve_right_nxt;  // serve direction for the next launch
  logic             r_scorer_one, w_scorer_one_nxt;    // who took the pending point

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_ball_x      <= BALL_X0;
      r_ball_y      <= BALL_Y0;
      r_dx          <= 1'b1;
      r_dy          <= 1'b1;
      r_pad1_y      <= PAD_Y0;
      r_pad2_y      <= PAD_Y0;
      r_score_one   <= '0;
      r_score_two   <= '0;
      r_game_over   <= 1'b0;
      r_frame_cnt   <= '0;
      r_serve_right <= 1'b1;
      r_scorer_one  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ball_x      <= w_ball_x_nxt;
      r_ball_y      <= w_ball_y_nxt;
      r_dx          <= w_dx_nxt;
      r_dy          <= w_dy_nxt;
      r_pad1_y      <= w_pad1_y_nxt;
      r_pad2_y      <= w_pad2_y_nxt;
      r_score_one   <= w_score_one_nxt;
      r_score_two   <= w_score_two_nxt;
      r_game_over   <= w_game_over_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_serve_right <= w_serve_right_nxt;
      r_scorer_one  <= w_scorer_one_nxt;
    end
  end

  // Paddle step with clamping; both buttons together cancel.
  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
    logic [10:0] y_w;
    y_w      = {1'b0, y};
    pad_step = y;
    if (up && !dn) begin
      if (y_w <= W_PSPD) pad_step = '0;
      else               pad_step = 10'(y_w - W_PSPD);
    end else if (dn && !up) begin
      if (y_w + W_PSPD >= {1'b0, PAD_Y_MAX}) pad_step = PAD_Y_MAX;
      else                                   pad_step = 10'(y_w + W_PSPD);
    end
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Ball collision terms (current-frame positions)
  // ---------------------------------------------------------------------------------------------
  logic [10:0] w_bx, w_by, w_p1y, w_p2y;
  logic        w_ovl_one, w_ovl_two;
  logic        w_hit_one, w_hit_two;
  logic        w_miss_left, w_miss_right;
  logic        w_wall_bottom, w_wall_top;
  logic        w_pads_live;

  assign w_bx  = {1'b0, r_ball_x};
  assign w_by  = {1'b0, r_ball_y};
  assign w_p1y = {1'b0, r_pad1_y};
  assign w_p2y = {1'b0, r_pad2_y};

  assign w_ovl_one = (w_by + W_BS > w_p1y) && (w_by < w_p1y + W_PH);
  assign w_ovl_two = (w_by + W_BS > w_p2y) && (w_by < w_p2y + W_PH);

  // x - SPD <= face is rewritten as x <= face + SPD so it cannot underflow.
  assign w_hit_one    = !r_dx && (w_bx <= HIT1_X + W_BSPD) && w_ovl_one;
  assign w_hit_two    = r_dx && (w_bx + W_BS + W_BSPD >= HIT2_X) && w_ovl_two;
  assign w_miss_left  = !r_dx && !w_hit_one && (w_bx <= W_BSPD);              // player two scores
  assign w_miss_right = r_dx && !w_hit_two && (w_bx + W_BS + W_BSPD >= W_SCR_W); // player one

  assign w_wall_bottom = r_dy && (w_by + W_BS + W_BSPD >= W_SCR_H);
  assign w_wall_top    = !r_dy && (w_by <= W_BSPD);

  assign w_pads_live = (r_state == StServe) || (r_state == StPlay) || (r_state == StPoint);

  // ---------------------------------------------------------------------------------------------
  // Next-state logic; everything is held except on a frame tick
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_ball_x_nxt      = r_ball_x;
    w_ball_y_nxt      = r_ball_y;
    w_dx_nxt          = r_dx;
    w_dy_nxt          = r_dy;
    w_pad1_y_nxt      = r_pad1_y;
    w_pad2_y_nxt      = r_pad2_y;
    w_score_one_nxt   = r_score_one;
    w_score_two_nxt   = r_score_two;
    w_game_over_nxt   = r_game_over;
    w_frame_cnt_nxt   = r_frame_cnt;
    w_serve_right_nxt = r_serve_right;
    w_scorer_one_nxt  = r_scorer_one;

    if (w_frame_tick) begin
      if (w_pads_live) begin
        w_pad1_y_nxt = pad_step(r_pad1_y, w_p1_up, w_p1_dn);
        w_pad2_y_nxt = pad_step(r_pad2_y, w_p2_up, w_p2_dn);
      end

      case (r_state)
        StIdle, StGameOver: begin
          if (w_start) begin
            w_state_nxt       = StServe;
            w_score_one_nxt   = '0;
            w_score_two_nxt   = '0;
            w_game_over_nxt   = 1'b0;
            w_frame_cnt_nxt   = '0;
            w_serve_right_nxt = 1'b1;
            w_ball_x_nxt      = BALL_X0;
            w_ball_y_nxt      = BALL_Y0;
          end
        end

        StServe: begin
          if (r_frame_cnt == CNT_LAST) begin
            w_state_nxt     = StPlay;
            w_frame_cnt_nxt = '0;
            w_dx_nxt        = r_serve_right;
            w_dy_nxt        = 1'b1;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 1'b1;
          end
        end

        StPlay: begin
          if (w_miss_left || w_miss_right) begin
            // A point freezes the ball and discards any bounce from this frame.
            w_state_nxt      = StPoint;
            w_scorer_one_nxt = w_miss_right;
          end else begin
            if (w_hit_one) begin
              w_ball_x_nxt = 10'(HIT1_X);
              w_dx_nxt     = 1'b1;
            end else if (w_hit_two) begin
              w_ball_x_nxt = 10'(HIT2_X - W_BS);
              w_dx_nxt     = 1'b0;
            end else if (r_dx) begin
              w_ball_x_nxt = 10'(w_bx + W_BSPD);
            end else begin
              w_ball_x_nxt = 10'(w_bx - W_BSPD);
            end

            if (w_wall_bottom) begin
              w_ball_y_nxt = 10'(W_SCR_H - W_BS);
              w_dy_nxt     = 1'b0;
            end else if (w_wall_top) begin
              w_ball_y_nxt = '0;
              w_dy_nxt     = 1'b1;
            end else if (r_dy) begin
              w_ball_y_nxt = 10'(w_by + W_BSPD);
            end else begin
              w_ball_y_nxt = 10'(w_by - W_BSPD);
            end
          end
        end

        StPoint: begin
          w_ball_x_nxt    = BALL_X0;
          w_ball_y_nxt    = BALL_Y0;
          w_frame_cnt_nxt = '0;
          // Next serve heads toward the player who just lost the point.
          w_serve_right_nxt = r_scorer_one;
          if (r_scorer_one) begin
            w_score_one_nxt = r_score_one + 4'd1;
          end else begin
            w_score_two_nxt = r_score_two + 4'd1;
          end
          if ((r_scorer_one ? r_score_one + 4'd1 : r_score_two + 4'd1) == WIN) begin
            w_state_nxt     = StGameOver;
            w_game_over_nxt = 1'b1;
          end else begin
            w_state_nxt = StServe;
          end
        end

        default: w_state_nxt = StIdle;
      endcase
    end
  end

  assign ball_x       = r_ball_x;
  assign ball_y       = r_ball_y;
  assign paddle_one_x = PAD1_X;
  assign paddle_two_x = PAD2_X;
  assign paddle_one_y = r_pad1_y;
  assign paddle_two_y = r_pad2_y;
  assign score_one    = r_score_one;
  assign score_two    = r_score_two;
  assign game_over    = r_game_over;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed self-checking bench for pong_game_ctrl. VS is driven directly so a
// frame lasts only a few clocks; corner positions are planted by briefly forcing DUT registers.
module tb_pong_game_ctrl;

  logic       clk50M = 1'b0;
  logic       rst_n;
  logic       VS;
  logic       p1_up, p1_down, p2_up, p2_down, start;
  logic [9:0] ball_x, ball_y, paddle_one_x, paddle_one_y, paddle_two_x, paddle_two_y;
  logic [3:0] score_one, score_two;
  logic       game_over;

  int errors = 0;
  int checks = 0;

  always #10 clk50M = ~clk50M;

  pong_game_ctrl dut (
    .clk50M       (clk50M),
    .rst_n        (rst_n),
    .VS           (VS),
    .p1_up        (p1_up),
    .p1_down      (p1_down),
    .p2_up        (p2_up),
    .p2_down      (p2_down),
    .start        (start),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .paddle_one_x (paddle_one_x),
    .paddle_one_y (paddle_one_y),
    .paddle_two_x (paddle_two_x),
    .paddle_two_y (paddle_two_y),
    .score_one    (score_one),
    .score_two    (score_two),
    .game_over    (game_over)
  );

  // One VS period: high long enough for buttons to settle, then a falling edge.
  task automatic frame();
    repeat (4) @(negedge clk50M);
    VS = 1'b0;
    repeat (4) @(negedge clk50M);
    VS = 1'b1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; VS = 1'b1; start = 1'b0;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    repeat (3) @(negedge clk50M);
    rst_n = 1'b1;
    repeat (3) @(negedge clk50M);
    checks++; if (ball_x !== 10'd316) begin errors++; $display("FAIL reset_ball_x got=%0d exp=316", ball_x); end
    checks++; if (ball_y !== 10'd236) begin errors++; $display("FAIL reset_ball_y got=%0d exp=236", ball_y); end
    checks++; if (paddle_one_x !== 10'd16) begin errors++; $display("FAIL reset_p1x got=%0d exp=16", paddle_one_x); end
    checks++; if (paddle_two_x !== 10'd616) begin errors++; $display("FAIL reset_p2x got=%0d exp=616", paddle_two_x); end
    checks++; if (paddle_one_y !== 10'd208) begin errors++; $display("FAIL reset_p1y got=%0d exp=208", paddle_one_y); end
    checks++; if (paddle_two_y !== 10'd208) begin errors++; $display("FAIL reset_p2y got=%0d exp=208", paddle_two_y); end
    checks++; if (score_one !== 4'd0 || score_two !== 4'd0) begin errors++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", score_one, score_two); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got=%0d exp=0", game_over); end
    checks++; if (dut.r_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dut.r_state); end
    // A frame without start stays idle, paddles frozen even with a button held.
    p1_up = 1'b1;
    frame();
    p1_up = 1'b0;
    checks++; if (dut.r_state !== 3'd0) begin errors++; $display("FAIL idle_hold_state got=%0d exp=0", dut.r_state); end
    checks++; if (paddle_one_y !== 10'd208) begin errors++; $display("FAIL idle_pad_frozen got=%0d exp=208", paddle_one_y); end
  endtask

  task automatic test_serve();
    start = 1'b1;
    frame();
    start = 1'b0;
    checks++; if (dut.r_state !== 3'd1) begin errors++; $display("FAIL serve_enter got=%0d exp=1", dut.r_state); end
    frames(59);
    checks++; if (dut.r_state !== 3'd1) begin errors++; $display("FAIL serve_59 got=%0d exp=1", dut.r_state); end
    frame();
    checks++; if (dut.r_state !== 3'd2) begin errors++; $display("FAIL serve_60_play got=%0d exp=2", dut.r_state); end
    checks++; if (ball_x !== 10'd316 || ball_y !== 10'd236) begin errors++; $display("FAIL serve_ball_centre got=%0d,%0d exp=316,236", ball_x, ball_y); end
    frame();
    checks++; if (ball_x !== 10'd318 || ball_y !== 10'd238) begin errors++; $display("FAIL play_first_move got=%0d,%0d exp=318,238", ball_x, ball_y); end
  endtask

  task automatic test_paddle();
    p1_up = 1'b1; p2_down = 1'b1;
    frames(52);
    checks++; if (paddle_one_y !== 10'd0) begin errors++; $display("FAIL p1_reach_top got=%0d exp=0", paddle_one_y); end
    checks++; if (paddle_two_y !== 10'd416) begin errors++; $display("FAIL p2_reach_bottom got=%0d exp=416", paddle_two_y); end
    frames(8);
    checks++; if (paddle_one_y !== 10'd0) begin errors++; $display("FAIL p1_stay_top got=%0d exp=0", paddle_one_y); end
    checks++; if (paddle_two_y !== 10'd416) begin errors++; $display("FAIL p2_stay_bottom got=%0d exp=416", paddle_two_y); end
    p1_up = 1'b0; p2_down = 1'b0; p1_down = 1'b1;
    frames(2);
    checks++; if (paddle_one_y !== 10'd8) begin errors++; $display("FAIL p1_down got=%0d exp=8", paddle_one_y); end
    p1_up = 1'b1;
    frames(2);
    checks++; if (paddle_one_y !== 10'd8) begin errors++; $display("FAIL p1_both got=%0d exp=8", paddle_one_y); end
    p1_up = 1'b0; p1_down = 1'b0;
    // 65 frames of free flight since launch from (316,236).
    checks++; if (ball_x !== 10'd446 || ball_y !== 10'd366) begin errors++; $display("FAIL ball_flight got=%0d,%0d exp=446,366", ball_x, ball_y); end
  endtask

  task automatic test_wall_bounce();
    @(negedge clk50M);
    force dut.r_ball_x = 10'd300; force dut.r_ball_y = 10'd471;
    force dut.r_dx = 1'b1; force dut.r_dy = 1'b1;
    @(negedge clk50M);
    release dut.r_ball_x; release dut.r_ball_y; release dut.r_dx; release dut.r_dy;
    frame();
    checks++; if (ball_y !== 10'd472) begin errors++; $display("FAIL bottom_clamp got=%0d exp=472", ball_y); end
    checks++; if (dut.r_dy !== 1'b0) begin errors++; $display("FAIL bottom_dy_up got=%0d exp=0", dut.r_dy); end
    checks++; if (ball_x !== 10'd302) begin errors++; $display("FAIL bottom_x got=%0d exp=302", ball_x); end
    frame();
    checks++; if (ball_y !== 10'd470) begin errors++; $display("FAIL after_bounce_y got=%0d exp=470", ball_y); end
    @(negedge clk50M);
    force dut.r_ball_y = 10'd2; force dut.r_dy = 1'b0;
    @(negedge clk50M);
    release dut.r_ball_y; release dut.r_dy;
    frame();
    checks++; if (ball_y !== 10'd0 || dut.r_dy !== 1'b1) begin errors++; $display("FAIL top_bounce got=%0d dy=%0d exp=0 dy=1", ball_y, dut.r_dy); end
  endtask

  task automatic test_paddle_hit();
    @(negedge clk50M);
    force dut.r_ball_x = 10'd25; force dut.r_ball_y = 10'd18;
    force dut.r_dx = 1'b0; force dut.r_dy = 1'b1;
    @(negedge clk50M);
    release dut.r_ball_x; release dut.r_ball_y; release dut.r_dx; release dut.r_dy;
    frame();
    checks++; if (ball_x !== 10'd24) begin errors++; $display("FAIL p1_hit_x got=%0d exp=24", ball_x); end
    checks++; if (dut.r_dx !== 1'b1) begin errors++; $display("FAIL p1_hit_dx got=%0d exp=1", dut.r_dx); end
    checks++; if (ball_y !== 10'd20) begin errors++; $display("FAIL p1_hit_y got=%0d exp=20", ball_y); end
    frame();
    checks++; if (ball_x !== 10'd26) begin errors++; $display("FAIL p1_after_hit_x got=%0d exp=26", ball_x); end
  endtask

  task automatic test_point();
    @(negedge clk50M);
    force dut.r_ball_x = 10'd2; force dut.r_ball_y = 10'd300;
    force dut.r_dx = 1'b0; force dut.r_dy = 1'b1;
    @(negedge clk50M);
    release dut.r_ball_x; release dut.r_ball_y; release dut.r_dx; release dut.r_dy;
    frame();
    checks++; if (dut.r_state !== 3'd3) begin errors++; $display("FAIL point_state got=%0d exp=3", dut.r_state); end
    checks++; if (score_two !== 4'd0) begin errors++; $display("FAIL point_score_pending got=%0d exp=0", score_two); end
    frame();
    checks++; if (score_two !== 4'd1 || score_one !== 4'd0) begin errors++; $display("FAIL point_score got=%0d/%0d exp=0/1", score_one, score_two); end
    checks++; if (dut.r_state !== 3'd1) begin errors++; $display("FAIL point_to_serve got=%0d exp=1", dut.r_state); end
    checks++; if (ball_x !== 10'd316 || ball_y !== 10'd236) begin errors++; $display("FAIL point_centre got=%0d,%0d exp=316,236", ball_x, ball_y); end
    start = 1'b1;  // must be ignored while serving
    frames(59);
    checks++; if (dut.r_state !== 3'd1) begin errors++; $display("FAIL reserve_59 got=%0d exp=1", dut.r_state); end
    frame();
    start = 1'b0;
    checks++; if (dut.r_state !== 3'd2) begin errors++; $display("FAIL reserve_play got=%0d exp=2", dut.r_state); end
    frame();
    checks++; if (ball_x !== 10'd314 || ball_y !== 10'd238) begin errors++; $display("FAIL serve_left got=%0d,%0d exp=314,238", ball_x, ball_y); end
    checks++; if (score_two !== 4'd1) begin errors++; $display("FAIL start_ignored_score got=%0d exp=1", score_two); end
  endtask

  task automatic test_game_over();
    @(negedge clk50M);
    force dut.r_score_one = 4'd6;
    force dut.r_ball_x = 10'd630; force dut.r_ball_y = 10'd300;
    force dut.r_dx = 1'b1; force dut.r_dy = 1'b1;
    @(negedge clk50M);
    release dut.r_score_one; release dut.r_ball_x; release dut.r_ball_y;
    release dut.r_dx; release dut.r_dy;
    frame();
    checks++; if (dut.r_state !== 3'd3) begin errors++; $display("FAIL win_point_state got=%0d exp=3", dut.r_state); end
    frame();
    checks++; if (score_one !== 4'd7) begin errors++; $display("FAIL win_score got=%0d exp=7", score_one); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL win_game_over got=%0d exp=1", game_over); end
    checks++; if (dut.r_state !== 3'd4) begin errors++; $display("FAIL win_state got=%0d exp=4", dut.r_state); end
    checks++; if (ball_x !== 10'd316 || ball_y !== 10'd236) begin errors++; $display("FAIL win_centre got=%0d,%0d exp=316,236", ball_x, ball_y); end
    frame();
    checks++; if (dut.r_state !== 3'd4 || game_over !== 1'b1) begin errors++; $display("FAIL gameover_hold got=%0d go=%0d exp=4 go=1", dut.r_state, game_over); end
    start = 1'b1;
    frame();
    start = 1'b0;
    checks++; if (score_one !== 4'd0 || score_two !== 4'd0) begin errors++; $display("FAIL newgame_scores got=%0d/%0d exp=0/0", score_one, score_two); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL newgame_go got=%0d exp=0", game_over); end
    checks++; if (dut.r_state !== 3'd1) begin errors++; $display("FAIL newgame_state got=%0d exp=1", dut.r_state); end
  endtask

  task automatic test_reset_mid_play();
    frames(63);
    checks++; if (dut.r_state !== 3'd2) begin errors++; $display("FAIL midplay_state got=%0d exp=2", dut.r_state); end
    checks++; if (ball_x !== 10'd322 || ball_y !== 10'd242) begin errors++; $display("FAIL midplay_ball got=%0d,%0d exp=322,242", ball_x, ball_y); end
    @(negedge clk50M);
    #3 rst_n = 1'b0;
    #2;
    checks++; if (ball_x !== 10'd316 || ball_y !== 10'd236) begin errors++; $display("FAIL async_ball got=%0d,%0d exp=316,236", ball_x, ball_y); end
    checks++; if (paddle_one_y !== 10'd208 || paddle_two_y !== 10'd208) begin errors++; $display("FAIL async_pads got=%0d,%0d exp=208,208", paddle_one_y, paddle_two_y); end
    checks++; if (score_one !== 4'd0 || score_two !== 4'd0 || game_over !== 1'b0) begin errors++; $display("FAIL async_score got=%0d/%0d go=%0d exp=0/0 go=0", score_one, score_two, game_over); end
    checks++; if (dut.r_state !== 3'd0) begin errors++; $display("FAIL async_state got=%0d exp=0", dut.r_state); end
    checks++; if (dut.r_dx !== 1'b1 || dut.r_dy !== 1'b1) begin errors++; $display("FAIL async_dir got=%0d,%0d exp=1,1", dut.r_dx, dut.r_dy); end
    checks++; if (dut.r_frame_cnt !== '0) begin errors++; $display("FAIL async_cnt got=%0d exp=0", dut.r_frame_cnt); end
    @(negedge clk50M);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_serve();
    test_paddle();
    test_wall_bounce();
    test_paddle_hit();
    test_point();
    test_game_over();
    test_reset_mid_play();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
